fxp_issue_arbiter: RTL and testbench

FXP_ISSUE_ARBITER -- requirements
Module: fxp_issue_arbiter

---
 rtl/fxp_issue_arbiter.sv | 112 +++++++++++
 tb/tb_fxp_issue_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fxp_issue_arbiter.sv
// fxp_issue_arbiter: round-robin issue arbiter for a shared fixed-point unit with multi-cycle mul/div occupancy.
// Define FXP_ARB_DIV_EN to build the divider path; otherwise divides complete in one cycle flagged illegal.
module fxp_issue_arbiter #(
  parameter int NUM_THREADS = 2,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 34
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         req,
  input  logic [2*NUM_THREADS-1:0]       req_kind,
  input  logic [NUM_THREADS-1:0]         flush,
  output logic [NUM_THREADS-1:0]         gnt,
  output logic [$clog2(NUM_THREADS)-1:0] issue_thread,
  output logic                           busy,
  output logic                           result_valid,
  output logic [$clog2(NUM_THREADS)-1:0] result_thread,
  output logic                           result_illegal
);
  localparam int TW   = $clog2(NUM_THREADS);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC);
  typedef enum logic [1:0] {
    IDLE,
`ifdef FXP_ARB_DIV_EN
    BUSY_DIV,
`endif
    BUSY_MUL
  } state_t;
  state_t                 r_state, w_state_nx;
  logic [CW-1:0]          r_cnt, w_cnt_nx;
  logic [TW-1:0]          r_ptr, r_owner, w_idx;
  logic [NUM_THREADS-1:0] w_elig;
  logic [1:0]             w_kind;
  logic                   r_sc, w_any, w_mul, w_div, w_done;
`ifndef FXP_ARB_DIV_EN
  logic                   r_ill;
`endif
  always_comb begin
    int j;
    w_elig = req & ~flush;
    w_idx  = '0;
    // Descending scan so the nearest eligible thread after the pointer wins.
    for (int k = NUM_THREADS; k >= 1; k--) begin
      j = (int'(r_ptr) + k) % NUM_THREADS;
      if (w_elig[TW'(j)]) w_idx = TW'(j);
    end
  end
  assign w_any  = (r_state == IDLE) && !reset && |w_elig;
  assign w_kind = req_kind[{w_idx, 1'b0} +: 2];
  assign w_mul  = w_any && (w_kind == 2'd1);
`ifdef FXP_ARB_DIV_EN
  assign w_div  = w_any && (w_kind == 2'd2);
`else
  assign w_div  = 1'b0;
`endif
  assign gnt          = w_any ? (NUM_THREADS'(1) << w_idx) : '0;
  assign issue_thread = w_idx;
  assign busy         = (r_state != IDLE);
  assign w_done       = busy && (r_cnt == '0) && !flush[r_owner];
  assign result_valid = w_done || (r_sc && !flush[r_owner]);
  assign result_thread = r_owner;
`ifdef FXP_ARB_DIV_EN
  assign result_illegal = 1'b0;
`else
  assign result_illegal = r_ill && !flush[r_owner];
`endif
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == IDLE) begin
      if (w_mul) begin
        w_state_nx = BUSY_MUL;
        w_cnt_nx   = CW'(MUL_CYCLES - 1);
      end
`ifdef FXP_ARB_DIV_EN
      else if (w_div) begin
        w_state_nx = BUSY_DIV;
        w_cnt_nx   = CW'(DIV_CYCLES - 1);
      end
`endif
    end else if (flush[r_owner] || r_cnt == '0) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else begin
      w_cnt_nx   = r_cnt - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= TW'(NUM_THREADS - 1);
      r_sc    <= 1'b0;
`ifndef FXP_ARB_DIV_EN
      r_ill   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_sc    <= w_any && !w_mul && !w_div;
`ifndef FXP_ARB_DIV_EN
      r_ill   <= w_any && (w_kind == 2'd2);
`endif
      if (w_any) begin
        r_owner <= w_idx;
        r_ptr   <= w_idx;
      end
    end
  end
endmodule

// File: tb/tb_fxp_issue_arbiter.sv
// tb_fxp_issue_arbiter: directed checks of fxp_issue_arbiter with default parameters.
module tb_fxp_issue_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, flush, gnt;
  logic [3:0] req_kind;
  logic       issue_thread, busy, rv, rt, ri;
  int n_cmp = 0;
  int n_bad = 0;
  fxp_issue_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_kind(req_kind), .flush(flush),
    .gnt(gnt), .issue_thread(issue_thread), .busy(busy), .result_valid(rv),
    .result_thread(rt), .result_illegal(ri)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [1:0] r, input logic [3:0] k, input logic [1:0] f);
    @(posedge clk);
    #1;
    req = r;
    req_kind = k;
    flush = f;
    #2;
  endtask
  task automatic outs(input string tag, input logic [1:0] g, input logic b, input logic v, input logic t);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".rv"}, 32'(rv), 32'(v));
    if (v) check({tag, ".rt"}, 32'(rt), 32'(t));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1; req = 2'b11; req_kind = 4'b0000; flush = 2'b00;
    #12;
    outs("rst", 2'b00, 0, 0, 0);
    check("rst.rt", 32'(rt), 0);
    check("rst.ri", 32'(ri), 0);
    @(posedge clk); #1; reset = 1'b0; req = 2'b00;
    go(2'b11, 0, 0); outs("rr0", 2'b01, 0, 0, 0);
    go(2'b11, 0, 0); outs("rr1", 2'b10, 0, 1, 0);
    go(2'b11, 0, 0); outs("rr2", 2'b01, 0, 1, 1);
    go(2'b11, 0, 0); outs("rr3", 2'b10, 0, 1, 0);
    go(2'b00, 0, 0); outs("rr4", 2'b00, 0, 1, 1);
    go(2'b00, 0, 0); outs("rr5", 2'b00, 0, 0, 0);
    go(2'b10, 4'b0100, 0); outs("mulg", 2'b10, 0, 0, 0);
    check("mulg.it", 32'(issue_thread), 1);
    for (int i = 1; i <= 4; i++) begin
      go(2'b11, 0, 0); outs($sformatf("mulb%0d", i), 2'b00, 1, i == 4, 1);
    end
    go(2'b11, 0, 0); outs("mul_n1", 2'b01, 0, 0, 0);
    go(2'b11, 0, 0); outs("mul_n2", 2'b10, 0, 1, 0);
    go(2'b00, 0, 0); outs("mul_n3", 2'b00, 0, 1, 1);
    go(2'b00, 0, 0); outs("mul_n4", 2'b00, 0, 0, 0);
    go(2'b01, 4'b0001, 0); outs("fo_g", 2'b01, 0, 0, 0);
    go(2'b00, 0, 0);       outs("fo_b", 2'b00, 1, 0, 0);
    go(2'b00, 0, 2'b01);   outs("fo_f", 2'b00, 1, 0, 0);
    go(2'b00, 0, 0);       outs("fo_i", 2'b00, 0, 0, 0);
    go(2'b00, 0, 0);       outs("fo_q", 2'b00, 0, 0, 0);
    go(2'b01, 4'b0001, 0); outs("fz_g", 2'b01, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      go(2'b00, 0, 0); outs("fz_b", 2'b00, 1, 0, 0);
    end
    go(2'b00, 0, 2'b01);   outs("fz_f", 2'b00, 1, 0, 0);
    go(2'b00, 0, 0);       outs("fz_i", 2'b00, 0, 0, 0);
    go(2'b01, 4'b0001, 0); outs("nf_g", 2'b01, 0, 0, 0);
    go(2'b00, 0, 0);       outs("nf_1", 2'b00, 1, 0, 0);
    go(2'b00, 0, 2'b10);   outs("nf_2", 2'b00, 1, 0, 0);
    go(2'b00, 0, 0);       outs("nf_3", 2'b00, 1, 0, 0);
    go(2'b00, 0, 0);       outs("nf_4", 2'b00, 1, 1, 0);
    go(2'b00, 0, 0);       outs("nf_5", 2'b00, 0, 0, 0);
    go(2'b10, 0, 0);       outs("sf_g", 2'b10, 0, 0, 0);
    go(2'b00, 0, 2'b10);   outs("sf_f", 2'b00, 0, 0, 0);
    go(2'b00, 0, 0);       outs("sf_q", 2'b00, 0, 0, 0);
    go(2'b01, 0, 2'b01);   outs("fb_0", 2'b00, 0, 0, 0);
    go(2'b11, 0, 2'b01);   outs("fb_1", 2'b10, 0, 0, 0);
    go(2'b00, 0, 0);       outs("fb_2", 2'b00, 0, 1, 1);
`ifdef FXP_ARB_DIV_EN
    go(2'b01, 4'b0010, 0); outs("dv_g", 2'b01, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      go(2'b11, 0, 0); outs("dv_b", 2'b00, 1, 0, 0);
    end
    go(2'b11, 0, 2'b01);   outs("dv_f", 2'b00, 1, 0, 0);
    go(2'b11, 0, 0);       outs("dv_r", 2'b10, 0, 0, 0);
    go(2'b00, 0, 0);       outs("dv_s", 2'b00, 0, 1, 1);
    go(2'b01, 4'b0010, 0); outs("dn_g", 2'b01, 0, 0, 0);
    for (int i = 1; i <= 34; i++) begin
      go(2'b00, 0, (i == 10) ? 2'b10 : 2'b00);
      outs($sformatf("dn_%0d", i), 2'b00, 1, i == 34, 0);
      if (i == 34) check("dn.ri", 32'(ri), 0);
    end
    go(2'b00, 0, 0);       outs("dn_q", 2'b00, 0, 0, 0);
`else
    go(2'b01, 4'b0010, 0); outs("il_g", 2'b01, 0, 0, 0);
    go(2'b00, 0, 0);       outs("il_r", 2'b00, 0, 1, 0);
    check("il.ri", 32'(ri), 1);
    go(2'b00, 0, 0);       outs("il_q", 2'b00, 0, 0, 0);
    check("il_q.ri", 32'(ri), 0);
    go(2'b10, 4'b1100, 0); outs("k3_g", 2'b10, 0, 0, 0);
    go(2'b00, 0, 0);       outs("k3_r", 2'b00, 0, 1, 1);
    check("k3.ri", 32'(ri), 0);
`endif
    go(2'b10, 4'b0100, 0); outs("rm_g", 2'b10, 0, 0, 0);
    go(2'b00, 0, 0);       outs("rm_1", 2'b00, 1, 0, 0);
    go(2'b00, 0, 0);       outs("rm_2", 2'b00, 1, 0, 0);
    #1; reset = 1'b1; #1;
    outs("rm_async", 2'b00, 0, 0, 0);
    go(2'b11, 0, 0);       outs("rm_hold", 2'b00, 0, 0, 0);
    @(posedge clk); #1; reset = 1'b0; req = 2'b00; #2;
    outs("rm_rel", 2'b00, 0, 0, 0);
    go(2'b11, 0, 0);       outs("rm_first", 2'b01, 0, 0, 0);
    go(2'b00, 0, 0);       outs("rm_res", 2'b00, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      go(2'b00, 0, 0); outs("rm_quiet", 2'b00, 0, 0, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
